// File: rtl/spi_swc_pkg.sv
// Shared SPI slave/controller definitions: state encodings, mode defaults, bit-order helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package spi_swc_pkg;

    localparam logic SPI_CPOL_DEFAULT         = 1'b0;
    localparam logic SPI_CPHA_DEFAULT         = 1'b0;
    localparam int   SPI_IDLE_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

    // Frame format, captured once at the start of each frame.
    typedef struct packed {
        logic dff;       // 1 = 16-bit word, 0 = 8-bit word
        logic lsbfirst;  // 1 = bit 0 travels first
    } frame_cfg_t;

    function automatic logic [4:0] frame_bits(input logic dff);
        return dff ? 5'd16 : 5'd8;
    endfunction

    // Bit of a transmit word that goes out on the wire first.
    function automatic logic first_tx_bit(input logic [15:0] w, input frame_cfg_t cfg);
        if (cfg.lsbfirst) begin
            return w[0];
        end else if (cfg.dff) begin
            return w[15];
        end else begin
            return w[7];
        end
    endfunction

    // The receive shifter always fills from bit 0 upward, so the first wire bit
    // ends up at position (frame_bits-1); LSB-first words need reversing.
    function automatic logic [15:0] assemble_rx(input logic [15:0] sh, input frame_cfg_t cfg);
        logic [15:0] r;
        r = '0;
        if (cfg.dff) begin
            if (cfg.lsbfirst) begin
                for (int i = 0; i < 16; i++) r[i] = sh[15-i];
            end else begin
                r = sh;
            end
        end else begin
            if (cfg.lsbfirst) begin
                for (int i = 0; i < 8; i++) r[i] = sh[7-i];
            end else begin
                r[7:0] = sh[7:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2_swc.sv
// Two-flop synchronizer bringing an asynchronous pin into the pclk domain.
// Latency: 2 pclk cycles from pin change to q.
// Backpressure: none; samples every cycle.
module sync2_swc #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic pclk,
    input  logic prst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronisation, reset to the line's idle level.
    always_ff @(posedge pclk) begin
        if (prst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spislave_swc.sv
// SPI slave: one 8/16-bit word per frame with rx/tx valid-ready word handshakes.
// Latency: 3 pclk cycles from sck pin edge to decision; rx_valid one cycle after the last sample edge.
// Backpressure: a finished word is dropped (rx_ovr) if the previous one is unread; tx_ready only in IDLE with an empty shadow.
module spislave_swc
    import spi_swc_pkg::*;
#(
    parameter logic CPOL         = SPI_CPOL_DEFAULT,
    parameter logic CPHA         = SPI_CPHA_DEFAULT,
    parameter int   IDLE_TIMEOUT = SPI_IDLE_TIMEOUT_DEFAULT
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    input  logic        dff,
    input  logic        lsbfirst,
    output logic        rx_valid,
    output logic [15:0] rx_data,
    input  logic        rx_ready,
    input  logic        tx_valid,
    input  logic [15:0] tx_data,
    output logic        tx_ready,
    output logic        busy,
    output logic        rx_ovr,
    output logic        tx_udr,
    output logic        frame_abort
);

    localparam int            IW        = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    logic          sck_s;
    logic          mosi_s;
    logic          sck_d;
    spi_state_t    state;
    spi_state_t    state_nxt;
    frame_cfg_t    cfg;
    frame_cfg_t    cfg_live;
    logic [4:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic [15:0]   rx_shift;
    logic [15:0]   tx_shift;
    logic [15:0]   tx_next;
    logic [15:0]   tx_shadow;
    logic [15:0]   tx_word;
    logic          tx_loaded;
    logic          tx_fire;
    logic          rx_pop;

    logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic start, capture, advance, abort, load_rx, drop_rx;

    sync2_swc #(.RST_VAL(CPOL)) u_sync_sck (
        .pclk (pclk),
        .prst (prst),
        .d    (sck),
        .q    (sck_s)
    );

    sync2_swc #(.RST_VAL(CPOL)) u_sync_mosi (
        .pclk (pclk),
        .prst (prst),
        .d    (mosi),
        .q    (mosi_s)
    );

    // Edge classification on the synchronized sck; mosi_s is aligned with sck_s.
    assign sck_edge    = sck_s ^ sck_d;
    assign lead_edge   = sck_edge && (sck_s != CPOL);
    assign trail_edge  = sck_edge && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign cfg_live = '{dff: dff, lsbfirst: lsbfirst};
    assign tx_ready = (state == ST_IDLE) && !tx_loaded;
    assign tx_fire  = tx_valid && tx_ready;
    assign tx_word  = tx_loaded ? tx_shadow : 16'h0000;
    assign tx_next  = cfg.lsbfirst ? (tx_shift >> 1) : (tx_shift << 1);
    assign rx_pop   = rx_valid && rx_ready;
    assign busy     = (state != ST_IDLE);

    // Remember the previous synchronized sck level for edge detection.
    always_ff @(posedge pclk) begin
        if (prst) sck_d <= CPOL;
        else      sck_d <= sck_s;
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (prst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state and single-cycle control strobes for the datapath.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        abort     = 1'b0;
        load_rx   = 1'b0;
        drop_rx   = 1'b0;
        case (state)
            ST_IDLE: begin
                // In CPHA=1 the frame opens with a shift-type edge that carries no data.
                if (!CPHA && sample_edge) begin
                    start     = 1'b1;
                    capture   = 1'b1;
                    state_nxt = ST_SHIFT;
                end else if (CPHA && lead_edge) begin
                    start     = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sample_edge) begin
                    capture = 1'b1;
                    if (bit_cnt + 5'd1 == frame_bits(cfg.dff)) state_nxt = ST_DONE;
                end else if (shift_edge) begin
                    advance = 1'b1;
                end else if (idle_cnt == IDLE_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!rx_valid || rx_ready) load_rx = 1'b1;
                else                       drop_rx = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame format latch, bit counter and receive shifter.
    always_ff @(posedge pclk) begin
        if (prst) begin
            cfg      <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (start) begin
            cfg      <= cfg_live;
            rx_shift <= capture ? {15'd0, mosi_s} : 16'h0000;
            bit_cnt  <= capture ? 5'd1 : 5'd0;
        end else if (capture) begin
            rx_shift <= {rx_shift[14:0], mosi_s};
            bit_cnt  <= bit_cnt + 5'd1;
        end else if (state == ST_IDLE) begin
            bit_cnt  <= '0;
        end
    end

    // Stall watchdog: counts pclk cycles since the last sck edge while mid-frame.
    always_ff @(posedge pclk) begin
        if (prst)                                idle_cnt <= '0;
        else if (state != ST_SHIFT || sck_edge)  idle_cnt <= '0;
        else                                     idle_cnt <= idle_cnt + 1'b1;
    end

    // Received-word holding register; a pop and a reload in the same cycle keeps valid high.
    always_ff @(posedge pclk) begin
        if (prst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (load_rx) begin
            rx_data  <= assemble_rx(rx_shift, cfg);
            rx_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end

    // Transmit shadow; a word accepted in the start cycle is kept for the next frame.
    always_ff @(posedge pclk) begin
        if (prst) begin
            tx_loaded <= 1'b0;
            tx_shadow <= '0;
        end else begin
            if (start) tx_loaded <= 1'b0;
            if (tx_fire) begin
                tx_shadow <= tx_data;
                tx_loaded <= 1'b1;
            end
        end
    end

    // miso driver: first bit while idle, next bit on every shift edge of the frame.
    always_ff @(posedge pclk) begin
        if (prst) begin
            miso     <= 1'b0;
            tx_shift <= '0;
        end else if (start) begin
            tx_shift <= tx_word;
            miso     <= first_tx_bit(tx_word, cfg_live);
        end else if (advance) begin
            tx_shift <= tx_next;
            miso     <= first_tx_bit(tx_next, cfg);
        end else if (state == ST_IDLE) begin
            miso     <= tx_loaded ? first_tx_bit(tx_shadow, cfg_live) : 1'b0;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge pclk) begin
        if (prst) begin
            rx_ovr      <= 1'b0;
            tx_udr      <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_ovr      <= drop_rx;
            tx_udr      <= start && !tx_loaded;
            frame_abort <= abort;
        end
    end

endmodule

// File: tb/tb_spislave_swc.sv
// Bench for spislave_swc: mode-0 and mode-3 instances driven by a behavioural SPI master.
// Latency: not applicable.
// Backpressure: rx_ready driven explicitly per step.
module tb_spislave_swc;

    localparam int H  = 8;        // sck half period in pclk cycles
    localparam int HT = H * 10;   // same, in time units

    logic        pclk = 1'b0;
    logic        prst;
    logic        sck [2];
    logic        mosi [2];
    logic        miso [2];
    logic        dff [2];
    logic        lsbfirst [2];
    logic        rx_valid [2];
    logic [15:0] rx_data [2];
    logic        rx_ready [2];
    logic        tx_valid [2];
    logic [15:0] tx_data [2];
    logic        tx_ready [2];
    logic        busy [2];
    logic        rx_ovr [2];
    logic        tx_udr [2];
    logic        frame_abort [2];

    int unsigned busy_cnt [2];
    int unsigned ovr_cnt [2];
    int unsigned udr_cnt [2];
    int unsigned abort_cnt [2];
    int tests = 0;
    int fails = 0;

    always #5 pclk = ~pclk;

    spislave_swc #(.CPOL(1'b0), .CPHA(1'b0), .IDLE_TIMEOUT(64)) dut0 (
        .pclk(pclk), .prst(prst), .sck(sck[0]), .mosi(mosi[0]), .miso(miso[0]),
        .dff(dff[0]), .lsbfirst(lsbfirst[0]),
        .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .rx_ready(rx_ready[0]),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .rx_ovr(rx_ovr[0]), .tx_udr(tx_udr[0]), .frame_abort(frame_abort[0])
    );

    spislave_swc #(.CPOL(1'b1), .CPHA(1'b1), .IDLE_TIMEOUT(64)) dut3 (
        .pclk(pclk), .prst(prst), .sck(sck[1]), .mosi(mosi[1]), .miso(miso[1]),
        .dff(dff[1]), .lsbfirst(lsbfirst[1]),
        .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .rx_ready(rx_ready[1]),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .rx_ovr(rx_ovr[1]), .tx_udr(tx_udr[1]), .frame_abort(frame_abort[1])
    );

    // Running tallies of busy cycles and status pulses, sampled away from the active edge.
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy[d])        busy_cnt[d]  <= busy_cnt[d] + 1;
            if (rx_ovr[d])      ovr_cnt[d]   <= ovr_cnt[d] + 1;
            if (tx_udr[d])      udr_cnt[d]   <= udr_cnt[d] + 1;
            if (frame_abort[d]) abort_cnt[d] <= abort_cnt[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int d, input logic f16, input logic lsb);
        @(negedge pclk);
        dff[d]      = f16;
        lsbfirst[d] = lsb;
    endtask

    task automatic load_tx(input int d, input logic [15:0] w);
        bit ok;
        ok = 1'b0;
        @(negedge pclk);
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        @(negedge pclk);
        tx_valid[d] = 1'b0;
        check("tx_accept", 32'(ok), 32'd1);
    endtask

    task automatic pop_rx(input int d);
        @(negedge pclk);
        rx_ready[d] = 1'b1;
        @(negedge pclk);
        rx_ready[d] = 1'b0;
    endtask

    // SPI master: sends nsend bits of w (framed as nbits) and collects miso into got.
    task automatic spi_frame(input int d, input logic [15:0] w, input int nbits, input int nsend,
                             input logic lsb, output logic [15:0] got);
        logic cp;
        logic ph;
        int   b;
        cp  = (d == 1);
        ph  = (d == 1);
        got = '0;
        @(negedge pclk);
        for (int i = 0; i < nsend; i++) begin
            b = lsb ? i : nbits - 1 - i;
            if (!ph) begin
                mosi[d] = w[b];
                #HT;
                got[b] = miso[d];
                sck[d] = ~cp;
                #HT;
                sck[d] = cp;
            end else begin
                sck[d]  = ~cp;
                mosi[d] = w[b];
                #HT;
                got[b] = miso[d];
                sck[d] = cp;
                #HT;
            end
        end
        #HT;
    endtask

    initial begin
        logic [15:0] got;
        int unsigned b0, u0, o0, a0;

        for (int d = 0; d < 2; d++) begin
            sck[d]      = (d == 1);
            mosi[d]     = 1'b0;
            dff[d]      = 1'b0;
            lsbfirst[d] = 1'b0;
            rx_ready[d] = 1'b0;
            tx_valid[d] = 1'b0;
            tx_data[d]  = '0;
            busy_cnt[d] = 0; ovr_cnt[d] = 0; udr_cnt[d] = 0; abort_cnt[d] = 0;
        end
        prst = 1'b1;
        repeat (3) @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);

        // Reset values on both instances.
        for (int d = 0; d < 2; d++) begin
            check("rst_busy",     32'(busy[d]), 32'd0);
            check("rst_rx_valid", 32'(rx_valid[d]), 32'd0);
            check("rst_rx_data",  32'(rx_data[d]), 32'd0);
            check("rst_miso",     32'(miso[d]), 32'd0);
            check("rst_tx_ready", 32'(tx_ready[d]), 32'd1);
            check("rst_pulses",   32'(rx_ovr[d] | tx_udr[d] | frame_abort[d]), 32'd0);
        end

        // Mode 0, 8-bit MSB first: 0xA5 in, 0x3C out.
        set_cfg(0, 1'b0, 1'b0);
        load_tx(0, 16'h003C);
        b0 = busy_cnt[0]; u0 = udr_cnt[0];
        spi_frame(0, 16'h00A5, 8, 8, 1'b0, got);
        repeat (4) @(negedge pclk);
        check("m0_rx_data",  32'(rx_data[0]), 32'h00A5);
        check("m0_rx_valid", 32'(rx_valid[0]), 32'd1);
        check("m0_miso",     32'(got), 32'h003C);
        check("m0_busy_len", busy_cnt[0] - b0, 32'(14 * H + 1));
        check("m0_no_udr",   udr_cnt[0] - u0, 32'd0);
        check("m0_idle",     32'(busy[0]), 32'd0);
        pop_rx(0);
        check("m0_popped",   32'(rx_valid[0]), 32'd0);

        // Mode 3, 16-bit LSB first: 0x1234 in, 0xC35A out.
        set_cfg(1, 1'b1, 1'b1);
        load_tx(1, 16'hC35A);
        b0 = busy_cnt[1];
        spi_frame(1, 16'h1234, 16, 16, 1'b1, got);
        repeat (4) @(negedge pclk);
        check("m3_rx_data",  32'(rx_data[1]), 32'h1234);
        check("m3_rx_valid", 32'(rx_valid[1]), 32'd1);
        check("m3_miso",     32'(got), 32'hC35A);
        check("m3_busy_len", busy_cnt[1] - b0, 32'(31 * H + 1));
        pop_rx(1);

        // Overrun: second word dropped while the first is still unread.
        set_cfg(0, 1'b0, 1'b0);
        o0 = ovr_cnt[0];
        spi_frame(0, 16'h0011, 8, 8, 1'b0, got);
        spi_frame(0, 16'h0022, 8, 8, 1'b0, got);
        repeat (4) @(negedge pclk);
        check("ovr_held_data", 32'(rx_data[0]), 32'h0011);
        check("ovr_valid",     32'(rx_valid[0]), 32'd1);
        check("ovr_pulses",    ovr_cnt[0] - o0, 32'd1);
        pop_rx(0);
        check("ovr_popped",    32'(rx_valid[0]), 32'd0);

        // Stalled frame aborts, next frame is clean.
        a0 = abort_cnt[0];
        spi_frame(0, 16'h00FF, 8, 5, 1'b0, got);
        repeat (80) @(negedge pclk);
        check("abort_pulse",    abort_cnt[0] - a0, 32'd1);
        check("abort_no_valid", 32'(rx_valid[0]), 32'd0);
        check("abort_idle",     32'(busy[0]), 32'd0);
        spi_frame(0, 16'h005A, 8, 8, 1'b0, got);
        repeat (4) @(negedge pclk);
        check("post_abort_data",  32'(rx_data[0]), 32'h005A);
        check("post_abort_valid", 32'(rx_valid[0]), 32'd1);
        pop_rx(0);

        // Underrun: nothing loaded, miso must stay low.
        set_cfg(1, 1'b0, 1'b0);
        u0 = udr_cnt[1];
        spi_frame(1, 16'h00C3, 8, 8, 1'b0, got);
        repeat (4) @(negedge pclk);
        check("udr_pulse",   udr_cnt[1] - u0, 32'd1);
        check("udr_miso",    32'(got), 32'h0000);
        check("udr_rx_data", 32'(rx_data[1]), 32'h00C3);
        pop_rx(1);

        // Reset at bit 10 of a 16-bit frame.
        set_cfg(0, 1'b1, 1'b0);
        load_tx(0, 16'hFFFF);
        a0 = abort_cnt[0]; o0 = ovr_cnt[0]; u0 = udr_cnt[0];
        spi_frame(0, 16'hABCD, 16, 10, 1'b0, got);
        @(negedge pclk);
        prst = 1'b1;
        repeat (2) @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        check("mid_rst_busy",     32'(busy[0]), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("mid_rst_rx_data",  32'(rx_data[0]), 32'd0);
        check("mid_rst_miso",     32'(miso[0]), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready[0]), 32'd1);
        repeat (80) @(negedge pclk);
        check("mid_rst_no_pulse", (abort_cnt[0] - a0) + (ovr_cnt[0] - o0) + (udr_cnt[0] - u0), 32'd0);
        load_tx(0, 16'h1357);
        spi_frame(0, 16'hBEEF, 16, 16, 1'b0, got);
        repeat (4) @(negedge pclk);
        check("post_rst_rx_data", 32'(rx_data[0]), 32'hBEEF);
        check("post_rst_miso",    32'(got), 32'h1357);
        pop_rx(0);

        // Randomized frames against a word-level model.
        for (int n = 0; n < 10; n++) begin
            int          d;
            int          nb;
            logic        rdff, rlsb, ld;
            logic [15:0] mw, tw, mask;
            d    = n % 2;
            rdff = 1'($urandom_range(0, 1));
            rlsb = 1'($urandom_range(0, 1));
            ld   = 1'($urandom_range(0, 1));
            mw   = 16'($urandom);
            tw   = 16'($urandom);
            nb   = rdff ? 16 : 8;
            mask = rdff ? 16'hFFFF : 16'h00FF;
            set_cfg(d, rdff, rlsb);
            if (ld) load_tx(d, tw);
            u0 = udr_cnt[d];
            spi_frame(d, mw, nb, nb, rlsb, got);
            repeat (4) @(negedge pclk);
            check("rnd_rx_data",  32'(rx_data[d]), 32'(mw & mask));
            check("rnd_rx_valid", 32'(rx_valid[d]), 32'd1);
            check("rnd_miso",     32'(got), ld ? 32'(tw & mask) : 32'd0);
            check("rnd_udr",      udr_cnt[d] - u0, 32'(!ld));
            pop_rx(d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
